// File: rtl/pcie_deframer.sv
// pcie_deframer: classifies PCIe 8b symbols and extracts TLP/DLLP payload.
// Ports: clk, reset (sync, active high), enb, data_in[7:0], k_in in;
//   data_out[7:0], valid_out, sym_code[3:0], sop, eop, err, pkt_cnt[7:0] out.
// Define DEFRAMER_SKP_STRIP_EN to report COM/SKP of a SKP ordered set as IDL.
module pcie_deframer #(
    parameter int MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [7:0] data_in,
    input  logic       k_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [3:0] sym_code,
    output logic       sop,
    output logic       eop,
    output logic       err,
    output logic [7:0] pkt_cnt
);

`ifdef DEFRAMER_SKP_STRIP_EN
    localparam logic STRIP = 1'b1;
`else
    localparam logic STRIP = 1'b0;
`endif

    // Counter must hold both the TLP limit and the fixed DLLP length.
    localparam int LIM = (MAX_LEN > 6) ? MAX_LEN : 6;
    localparam int LW  = $clog2(LIM + 1);

    localparam logic [3:0] C_COM  = 4'b0000;
    localparam logic [3:0] C_DATA = 4'b0010;
    localparam logic [3:0] C_SKP  = 4'b0011;
    localparam logic [3:0] C_STP  = 4'b0100;
    localparam logic [3:0] C_SDP  = 4'b0101;
    localparam logic [3:0] C_END  = 4'b0110;
    localparam logic [3:0] C_IDL  = 4'b1001;
    localparam logic [3:0] C_UNK  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TLP,
        S_DLLP,
        S_SKPOS
    } state_t;

    state_t      state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [2:0]  skp_q, skp_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [3:0]  sym_q, sym_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  code;
    logic        use_idle;
    logic [LW-1:0] lim;

    always_comb begin
        code = C_UNK;
        if (!k_in) begin
            code = C_DATA;
        end else begin
            unique case (data_in)
                8'hBC:   code = C_COM;
                8'hFB:   code = C_STP;
                8'h5C:   code = C_SDP;
                8'hFD:   code = C_END;
                8'h7C:   code = C_IDL;
                8'h1C:   code = C_SKP;
                default: code = C_UNK;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        skp_d      = skp_q;
        data_out_d = data_out_q;
        sym_d      = sym_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        use_idle   = 1'b0;
        lim        = (state_q == S_TLP) ? LW'(MAX_LEN) : LW'(6);
        if (enb) begin
            sym_d = code;
            unique case (state_q)
                S_IDLE: use_idle = 1'b1;
                S_SKPOS: begin
                    if (code == C_SKP) begin
                        // saturate: anything above 5 is already an error
                        if (skp_q != 3'd7) skp_d = skp_q + 3'd1;
                        sym_d = STRIP ? C_IDL : C_SKP;
                    end else begin
                        use_idle = 1'b1;
                        if (skp_q == 3'd0 || skp_q > 3'd5) err_d = 1'b1;
                    end
                end
                S_TLP, S_DLLP: begin
                    if (code == C_DATA) begin
                        if (len_q == lim) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                            len_d   = '0;
                        end else begin
                            valid_d    = 1'b1;
                            data_out_d = data_in;
                            len_d      = len_q + LW'(1);
                        end
                    end else if (code == C_END) begin
                        eop_d   = 1'b1;
                        state_d = S_IDLE;
                        len_d   = '0;
                        if (state_q == S_DLLP && len_q != LW'(6))
                            err_d = 1'b1;
                        else
                            cnt_d = cnt_q + 8'd1;
                    end else if (code == C_STP || code == C_SDP) begin
                        // abort current packet, start the new one now
                        err_d   = 1'b1;
                        sop_d   = 1'b1;
                        len_d   = '0;
                        state_d = (code == C_STP) ? S_TLP : S_DLLP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        len_d   = '0;
                    end
                end
            endcase
            // IDLE rules; also applied to the byte that ends a SKP set
            if (use_idle) begin
                len_d   = '0;
                skp_d   = '0;
                state_d = S_IDLE;
                if (code == C_STP) begin
                    state_d = S_TLP;
                    sop_d   = 1'b1;
                end else if (code == C_SDP) begin
                    state_d = S_DLLP;
                    sop_d   = 1'b1;
                end else if (code == C_COM) begin
                    state_d = S_SKPOS;
                    sym_d   = STRIP ? C_IDL : C_COM;
                end else if (code != C_IDL) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            skp_q      <= '0;
            data_out_q <= 8'h00;
            sym_q      <= C_IDL;
            cnt_q      <= 8'h00;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            skp_q      <= skp_d;
            data_out_q <= data_out_d;
            sym_q      <= sym_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign sym_code  = sym_q;
    assign sop       = sop_q;
    assign eop       = eop_q;
    assign err       = err_q;
    assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_pcie_deframer.sv
// tb_pcie_deframer: directed and randomized symbol streams for pcie_deframer
// checked every cycle against a packet-level reference model.
module tb_pcie_deframer;

    localparam int MAX_LEN = 32;
`ifdef DEFRAMER_SKP_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       k_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic [3:0] sym_code;
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] pkt_cnt;

    pcie_deframer #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .enb(enb),
        .data_in(data_in), .k_in(k_in),
        .data_out(data_out), .valid_out(valid_out),
        .sym_code(sym_code), .sop(sop), .eop(eop),
        .err(err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 TLP, 2 DLLP, 3 inside SKP set
    int          m_mode = 0;
    int          m_skips = 0;
    byte unsigned m_pay[$];
    logic [7:0]  e_data = 0;
    logic        e_valid = 0, e_sop = 0, e_eop = 0, e_err = 0;
    logic [3:0]  e_sym = 4'b1001;
    int          e_cnt = 0;

    function automatic logic [3:0] sym_of(input logic k, input logic [7:0] d);
        if (!k) return 4'b0010;
        case (d)
            8'hBC:   return 4'b0000;
            8'hFB:   return 4'b0100;
            8'h5C:   return 4'b0101;
            8'hFD:   return 4'b0110;
            8'h7C:   return 4'b1001;
            8'h1C:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic model(input bit rst, input bit en, input bit k,
                         input logic [7:0] d);
        logic [3:0] s;
        bit reidle;
        int limit;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0;
        if (rst) begin
            m_mode = 0; m_skips = 0; m_pay.delete();
            e_data = 0; e_sym = 4'b1001; e_cnt = 0;
            return;
        end
        if (!en) return;
        s = sym_of(k, d);
        e_sym = s;
        reidle = 0;
        if (m_mode == 0) begin
            reidle = 1;
        end else if (m_mode == 3) begin
            if (s == 4'b0011) begin
                m_skips++;
                if (STRIP) e_sym = 4'b1001;
            end else begin
                if (m_skips == 0 || m_skips > 5) e_err = 1;
                reidle = 1;
            end
        end else begin
            limit = (m_mode == 1) ? MAX_LEN : 6;
            if (s == 4'b0010) begin
                if (m_pay.size() == limit) begin
                    e_err = 1; m_mode = 0; m_pay.delete();
                end else begin
                    m_pay.push_back(d); e_valid = 1; e_data = d;
                end
            end else if (s == 4'b0110) begin
                e_eop = 1;
                if (m_mode == 2 && m_pay.size() != 6) e_err = 1;
                else e_cnt = (e_cnt + 1) % 256;
                m_mode = 0; m_pay.delete();
            end else if (s == 4'b0100 || s == 4'b0101) begin
                e_err = 1; e_sop = 1; m_pay.delete();
                m_mode = (s == 4'b0100) ? 1 : 2;
            end else begin
                e_err = 1; m_mode = 0; m_pay.delete();
            end
        end
        if (reidle) begin
            m_skips = 0; m_pay.delete(); m_mode = 0;
            if (s == 4'b0100) begin m_mode = 1; e_sop = 1; end
            else if (s == 4'b0101) begin m_mode = 2; e_sop = 1; end
            else if (s == 4'b0000) begin
                m_mode = 3;
                if (STRIP) e_sym = 4'b1001;
            end else if (s != 4'b1001) e_err = 1;
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit k,
                        input logic [7:0] d);
        @(negedge clk);
        reset = rst; enb = en; k_in = k; data_in = d;
        model(rst, en, k, d);
        @(posedge clk);
        #1;
        chk("data_out", 32'(data_out), 32'(e_data));
        chk("valid_out", 32'(valid_out), 32'(e_valid));
        chk("sym_code", 32'(sym_code), 32'(e_sym));
        chk("sop", 32'(sop), 32'(e_sop));
        chk("eop", 32'(eop), 32'(e_eop));
        chk("err", 32'(err), 32'(e_err));
        chk("pkt_cnt", 32'(pkt_cnt), 32'(e_cnt));
    endtask

    task automatic kb(input logic [7:0] d); step(0, 1, 1, d); endtask
    task automatic db(input logic [7:0] d); step(0, 1, 0, d); endtask
    task automatic rst1(); step(1, $urandom_range(0, 1), 1, 8'hFB); endtask

    initial begin
        rst1(); rst1();
        chk("rst_sym", 32'(sym_code), 32'h9);
        chk("rst_cnt", 32'(pkt_cnt), 32'h0);

        // good TLP
        kb(8'hFB); db(8'hA0); db(8'hA1); db(8'hA2); kb(8'hFD);
        chk("tlp_cnt", 32'(pkt_cnt), 32'd1);

        // good DLLP, then short DLLP
        rst1();
        kb(8'h5C);
        for (int i = 0; i < 6; i++) db(8'(i + 16));
        kb(8'hFD);
        chk("dllp_cnt", 32'(pkt_cnt), 32'd1);
        rst1();
        kb(8'h5C);
        for (int i = 0; i < 5; i++) db(8'(i));
        kb(8'hFD);
        chk("dllp5_err", 32'(err), 32'd1);
        chk("dllp5_cnt", 32'(pkt_cnt), 32'd0);

        // SKP ordered set
        kb(8'hBC);
        chk("com_sym", 32'(sym_code), STRIP ? 32'h9 : 32'h0);
        kb(8'h1C); kb(8'h1C); kb(8'h1C);
        chk("skp_sym", 32'(sym_code), STRIP ? 32'h9 : 32'h3);
        kb(8'hFB);
        chk("skp_sop", 32'(sop), 32'd1);
        kb(8'hFD);

        // violations
        db(8'h55);
        kb(8'hFB);
        for (int i = 0; i < MAX_LEN + 1; i++) db(8'($urandom));
        chk("long_err", 32'(err), 32'd1);
        kb(8'hFB); db(8'h11); kb(8'hFB);
        chk("nest_sop", 32'(sop & err), 32'd1);
        kb(8'hFD);

        // reset mid-TLP
        kb(8'hFB); db(8'h01); db(8'h02);
        rst1();
        kb(8'hFD);
        chk("post_rst_eop", 32'(eop), 32'd0);

        // hold
        kb(8'hFB); db(8'hC0);
        for (int i = 0; i < 3; i++) step(0, 0, $urandom_range(0, 1), 8'($urandom));
        db(8'hC1); kb(8'hFD);

        // wrap
        rst1();
        for (int i = 0; i < 256; i++) begin
            kb(8'hFB); db(8'(i)); kb(8'hFD);
        end
        chk("wrap", 32'(pkt_cnt), 32'd0);

        // structured random frames
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 4))
                0: begin
                    kb(8'hFB);
                    repeat ($urandom_range(0, MAX_LEN + 2)) db(8'($urandom));
                    kb(8'hFD);
                end
                1: begin
                    kb(8'h5C);
                    repeat ($urandom_range(4, 8)) db(8'($urandom));
                    kb(8'hFD);
                end
                2: begin
                    kb(8'hBC);
                    repeat ($urandom_range(0, 7)) kb(8'h1C);
                end
                3: step($urandom_range(0, 30) == 0, $urandom_range(0, 9) != 0,
                        $urandom_range(0, 1), 8'($urandom));
                default: kb(8'h7C);
            endcase
        end

        // unconstrained random symbols
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [7:0] d;
            bit k;
            r = $urandom_range(0, 99);
            k = 1;
            if (r < 45) begin k = 0; d = 8'($urandom); end
            else if (r < 55) d = 8'hFD;
            else if (r < 62) d = 8'hFB;
            else if (r < 66) d = 8'h5C;
            else if (r < 72) d = 8'hBC;
            else if (r < 85) d = 8'h1C;
            else if (r < 90) d = 8'h7C;
            else d = 8'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0, k, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_deframer.md
PCIE_DEFRAMER -- requirements
Module: pcie_deframer

Interface
REQ-001 Parameter MAX_LEN, default 32, is the maximum TLP payload bytes between STP and END.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 enb  input  1  lane enable; when low, input is ignored and state holds.
REQ-005 data_in  input  8  received symbol byte.
REQ-006 k_in  input  1  high marks data_in as a K (control) character.
REQ-007 data_out  output  8  payload byte.
REQ-008 valid_out  output  1  data_out carries payload this cycle.
REQ-009 sym_code  output  4  decoded symbol class: COM=0000, DATA=0010, SKP=0011, STP=0100, SDP=0101, END=0110, IDL=1001, unknown K=1111.
REQ-010 sop  output  1  one-cycle pulse on an accepted STP or SDP.
REQ-011 eop  output  1  one-cycle pulse on an END that closes a packet.
REQ-012 err  output  1  one-cycle pulse on a framing violation.
REQ-013 pkt_cnt  output  8  count of error-free packets closed.

Function
REQ-014 K decode: COM=0xBC, STP=0xFB, SDP=0x5C, END=0xFD, IDL=0x7C, SKP=0x1C; any other K byte is unknown (1111).
REQ-015 All outputs are registered; the response to a byte appears exactly 1 cycle after it is sampled with enb=1.
REQ-016 The FSM has four states: IDLE, TLP, DLLP, SKPOS.
REQ-017 IDLE handles bytes as follows:
- STP: go to TLP, sop=1.
- SDP: go to DLLP, sop=1.
- COM: go to SKPOS.
- IDL: stay in IDLE.
- data byte or unknown K: err=1, byte discarded, valid_out=0.
REQ-018 TLP/DLLP data bytes: data_out=data_in, valid_out=1, length counter increments.
REQ-019 TLP/DLLP END: eop=1, go to IDLE, length cleared; pkt_cnt increments only if no err was raised for that packet.
REQ-020 STP or SDP inside a packet: err=1, current packet aborted without eop, the new packet starts with sop=1 in the same cycle.
REQ-021 COM, IDL, SKP or unknown K inside a packet: err=1, go to IDLE without eop.
REQ-022 In TLP, a data byte arriving with length already equal to MAX_LEN: err=1, byte dropped, go to IDLE.
REQ-023 In DLLP, END with length not equal to 6: eop=1 and err=1 in the same cycle, pkt_cnt unchanged; a 7th data byte raises err and returns to IDLE.
REQ-024 SKPOS handles bytes as follows:
- SKP: increments the skip counter; sym_code=SKP.
- First non-SKP byte: return to IDLE and process that byte with IDLE rules in the same cycle.
- Zero SKPs before that byte, or more than 5 SKPs: err=1.
REQ-025 sym_code reflects every sampled byte, including bytes that raise err.
REQ-026 pkt_cnt wraps 255 to 0 without error.
REQ-027 With enb=0: valid_out, sop, eop and err are 0; data_out, sym_code, the FSM, counters and pkt_cnt hold.

Reset
REQ-028 With reset high at a clk edge, the block enters IDLE and sets:
- data_out=0x00, valid_out=0, sop=0, eop=0, err=0, pkt_cnt=0, sym_code=IDL (1001).
- length and skip counters cleared.
REQ-029 Reset dominates enb and any in-flight packet; an aborted packet produces neither eop nor err.

Configuration
REQ-030 With macro DEFRAMER_SKP_STRIP_EN defined, bytes consumed in SKPOS (COM and SKPs) drive sym_code to IDL, so SKP ordered sets are invisible downstream; error checking on them is unchanged.
REQ-031 With DEFRAMER_SKP_STRIP_EN undefined, sym_code reports COM and SKP per REQ-009.

Verification
REQ-032 Good TLP: enb=1; STP, 0xA0, 0xA1, 0xA2, END -> sop, then valid_out with A0/A1/A2 on consecutive cycles, then eop; pkt_cnt=1; err never set.
REQ-033 Good DLLP: SDP, 6 data bytes, END -> 6 valid_out cycles, eop, pkt_cnt=1; the same stream with 5 data bytes -> eop and err together, pkt_cnt=0.
REQ-034 SKP ordered set: COM, SKP x3, STP -> no err, sop on the STP response; sym_code 0000, 0011 x3 without the macro, 1001 x4 with it.
REQ-035 Violations: data byte 0x55 in IDLE -> err, no valid_out; TLP of MAX_LEN+1 bytes -> err on byte 33, IDLE; STP inside TLP -> err and sop in the same cycle.
REQ-036 Reset mid-TLP (after STP plus 2 bytes) -> next cycle all outputs at reset values; a following END gives err (IDLE rules), no eop.
REQ-037 Hold and wrap: enb=0 for 3 cycles mid-TLP -> no valid_out and length held; resuming completes the packet normally. 256 good packets -> pkt_cnt=0.
